// File: rtl/uart_verici.sv
// rtl/uart_verici.sv - UART transmitter (8N1, LSB first) with a small byte FIFO
// Optional parity bit: define UART_VERICI_PARITE_EN (adds parite_tek_i and a PARITE state)

module uart_verici #(
  parameter int FIFO_DERINLIK = 8,
  parameter int DURMA_BIT     = 1
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             tx_en_i,
  input  logic [7:0]                       veri_i,
  input  logic                             veri_gecerli_i,
`ifdef UART_VERICI_PARITE_EN
  input  logic                             parite_tek_i,
`endif
  output logic                             hazir_o,
  input  logic [15:0]                      baud_div_i,
  output logic                             tx_o,
  output logic                             mesgul_o,
  output logic [$clog2(FIFO_DERINLIK):0]   fifo_doluluk_o
);

  localparam int AW = $clog2(FIFO_DERINLIK);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    BOSTA  = 3'd0,
    BASLA  = 3'd1,
    VERI   = 3'd2,
    DUR    = 3'd3,
    PARITE = 3'd4
  } durum_e;

  durum_e         durum_q, durum_d;
  logic [7:0]     mem_q [FIFO_DERINLIK];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  doluluk_q, doluluk_d;
  logic           hazir_q, hazir_d;
  logic [7:0]     shift_q, shift_d;
  logic [15:0]    div_q, div_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic           tx_q, tx_d;
  logic           mesgul_q, mesgul_d;
`ifdef UART_VERICI_PARITE_EN
  logic           parite_q, parite_d;
`endif

  logic           push;
  logic           pop;
  logic           bos;
  logic           tick;
  logic [7:0]     head;

  assign push = veri_gecerli_i && hazir_q;
  assign bos  = (doluluk_q == '0);
  assign tick = (cnt_q == div_q);
  assign head = mem_q[rd_ptr_q];

  // State and datapath registers; reset discards the queue and idles the line
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q   <= BOSTA;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      doluluk_q <= '0;
      hazir_q   <= 1'b1;
      shift_q   <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= 1'b1;
      mesgul_q  <= 1'b0;
`ifdef UART_VERICI_PARITE_EN
      parite_q  <= 1'b0;
`endif
    end else begin
      durum_q   <= durum_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      doluluk_q <= doluluk_d;
      hazir_q   <= hazir_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      mesgul_q  <= mesgul_d;
`ifdef UART_VERICI_PARITE_EN
      parite_q  <= parite_d;
`endif
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= veri_i;
    end
  end

  // Next-state logic; a pop happens exactly when a new frame is launched
  always_comb begin
    durum_d = durum_q;
    pop     = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (!bos && tx_en_i) begin
          pop     = 1'b1;
          durum_d = BASLA;
        end
      end
      BASLA: begin
        if (tick) durum_d = VERI;
      end
      VERI: begin
        if (tick && (bit_q == 3'd7)) begin
`ifdef UART_VERICI_PARITE_EN
          durum_d = PARITE;
`else
          durum_d = DUR;
`endif
        end
      end
`ifdef UART_VERICI_PARITE_EN
      PARITE: begin
        if (tick) durum_d = DUR;
      end
`endif
      DUR: begin
        if (tick && (bit_q == 3'(DURMA_BIT - 1))) begin
          if (!bos && tx_en_i) begin
            pop     = 1'b1;
            durum_d = BASLA;
          end else begin
            durum_d = BOSTA;
          end
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  // Baud counter, shift register, bit index and FIFO bookkeeping
  always_comb begin
    shift_d   = shift_q;
    div_d     = div_q;
    bit_d     = bit_q;
    cnt_d     = (durum_q == BOSTA || tick) ? 16'd0 : cnt_q + 16'd1;
`ifdef UART_VERICI_PARITE_EN
    parite_d  = parite_q;
`endif

    // The bit index wraps 7 -> 0 leaving VERI, so DUR counts stop bits from zero
    if (tick && durum_q == VERI) begin
      shift_d = {1'b0, shift_q[7:1]};
      bit_d   = bit_q + 3'd1;
    end else if (tick && durum_q == DUR) begin
      bit_d   = bit_q + 3'd1;
    end

    // Frame start: the divisor and parity mode are sampled once per frame
    if (pop) begin
      shift_d  = head;
      div_d    = baud_div_i;
      cnt_d    = 16'd0;
      bit_d    = 3'd0;
`ifdef UART_VERICI_PARITE_EN
      parite_d = (^head) ^ parite_tek_i;
`endif
    end

    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    doluluk_d = doluluk_q + CW'(push) - CW'(pop);
    hazir_d   = (doluluk_d != CW'(FIFO_DERINLIK));
  end

  // Output decode; registered so tx_o never sees a combinational input path
  always_comb begin
    tx_d = 1'b1;
    case (durum_q)
      BASLA:  tx_d = 1'b0;
      VERI:   tx_d = shift_q[0];
`ifdef UART_VERICI_PARITE_EN
      PARITE: tx_d = parite_q;
`endif
      default: tx_d = 1'b1;
    endcase
    mesgul_d = (durum_q != BOSTA) || !bos;
  end

  assign tx_o           = tx_q;
  assign hazir_o        = hazir_q;
  assign mesgul_o       = mesgul_q;
  assign fifo_doluluk_o = doluluk_q;

endmodule

// File: doc/uart_verici.md
Name: uart_verici

Overview:
- UART transmitter.
- Serialises bytes handed over by the peripheral bus side onto the `tx_o` line: 8N1 frames, LSB first.
- Uses the same `baud_div_i` convention as the UART receive path, so one register drives both directions.
- Contains a small FIFO so software can queue several bytes while a frame is on the line.

Parameters:
- FIFO_DERINLIK, 8, number of byte entries in the transmit FIFO; power of two, minimum 2.
- DURMA_BIT, 1, number of stop bits, 1 or 2.

Ports:
- clk_i  input  1  clock.
- rstn_i  input  1  reset, asynchronous, active-low.
- tx_en_i  input  1  transmit enable; gates the start of new frames only.
- veri_i  input  8  byte to queue.
- veri_gecerli_i  input  1  byte on `veri_i` is valid.
- hazir_o  output  1  FIFO can accept a byte (not full).
- baud_div_i  input  16  bit period minus one, in clk_i cycles.
- tx_o  output  1  serial output line, idle high.
- mesgul_o  output  1  a frame is in progress or the FIFO is non-empty.
- fifo_doluluk_o  output  $clog2(FIFO_DERINLIK)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rstn_i=0):
  - `tx_o`=1, `hazir_o`=1, `mesgul_o`=0, `fifo_doluluk_o`=0.
  - FSM goes to BOSTA; FIFO pointers are cleared.
  - Takes effect immediately, including mid-frame: the line returns high and the queued data is discarded.
- Push:
  - Occurs on a clk_i edge when `veri_gecerli_i` && `hazir_o`.
  - `hazir_o` = !full, registered.
  - When full, pushes are dropped even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
- Bit period: `baud_div_i`+1 cycles.
  - A 16-bit counter runs from 0 to the latched divisor, then wraps.
  - `baud_div_i` is latched at frame start; changes mid-frame take effect on the next frame.
  - `baud_div_i`=0 is legal and gives 1 cycle per bit.
- FSM states:
  - BOSTA: `tx_o`=1. If the FIFO is non-empty and `tx_en_i`=1: pop the head into the shift register, latch the divisor, clear the counter and bit index, go to BASLA.
  - BASLA: `tx_o`=0 for one bit period, then go to VERI.
  - VERI: `tx_o`=shift[0] for one bit period per bit. Shift right after each period. After bit index 7 completes, go to DUR (or PARITE when the optional feature is enabled).
  - DUR: `tx_o`=1 for DURMA_BIT bit periods. At the end:
    - if the FIFO is non-empty and `tx_en_i`=1, pop the next byte and enter BASLA directly, giving back-to-back frames with no idle gap;
    - otherwise go to BOSTA.
- `tx_o` is driven from a register; there is no combinational path from inputs to `tx_o`.
- Latency: a byte pushed into an empty FIFO while idle drives `tx_o`=0 after the second clk_i edge following the accepting edge.
- `tx_en_i` deasserted mid-frame: the current frame completes normally; no new frame starts. FIFO contents are retained.
- `mesgul_o` = (state != BOSTA) || FIFO non-empty.
- Frame length (8N1, DURMA_BIT=1): 10 × (`baud_div_i`+1) cycles.

Optional Feature:
- Macro: UART_VERICI_PARITE_EN.
- Defined:
  - Adds input port `parite_tek_i` (1 bit), latched at frame start.
  - Adds state PARITE between VERI and DUR, lasting one bit period.
  - Parity bit = XOR of the 8 data bits, inverted when `parite_tek_i`=1 (odd parity).
  - Frame becomes 11 bit periods.
- Undefined: no PARITE state and no `parite_tek_i` port; frame is 8N1.

Test Plan:
- Single byte: `baud_div_i`=3, push 0xA5 → `tx_o` = 0, then 1,0,1,0,0,1,0,1, then 1. Each level is held 4 cycles; total 40 cycles. `mesgul_o` falls the cycle `tx_o` re-enters BOSTA.
- Back-to-back: `baud_div_i`=1, push 0x00, 0xFF, 0x55 in consecutive cycles → three contiguous 20-cycle frames with no idle between stop and next start. `fifo_doluluk_o` steps 1→2→… and then down to 0.
- Full FIFO: `tx_en_i`=0, push 9 bytes with FIFO_DERINLIK=8 → `hazir_o`=0 after the 8th; the 9th is dropped. Raise `tx_en_i` → exactly 8 frames are sent.
- Mid-frame changes: during byte 0x3C, change `baud_div_i` 3→7 and drop `tx_en_i` → the current frame finishes at 4 cycles/bit and no further frame starts. With `tx_en_i` re-raised, the next frame runs at 8 cycles/bit.
- Reset mid-frame: assert `rstn_i`=0 during data bit 4 → `tx_o`=1 immediately (asynchronous), `fifo_doluluk_o`=0, `hazir_o`=1. After release the line stays idle.
- Parity (UART_VERICI_PARITE_EN): 0x07 with `parite_tek_i`=0 → parity bit 1. With `parite_tek_i`=1 → parity bit 0. Frame is 11 bit periods.
